// File: rtl/vga_scanout.sv
// VGA 640x480@60 scan-out: pixel timing, 4x4 upscaled framebuffer reads and DAC drive.
// Outputs trail the scan counters by one pixel tick so colour, sync and blank stay aligned.
module vga_scanout #(
   parameter int H_VISIBLE   = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_VISIBLE   = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int FB_WIDTH    = 160,
   parameter int SCALE_SHIFT = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [14:0] rd_addr,
   input  logic [2:0]  rd_data,
   output logic        frame_start,
   output logic        VGA_CLK,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_N,
   output logic        VGA_SYNC_N,
   output logic [9:0]  VGA_R,
   output logic [9:0]  VGA_G,
   output logic [9:0]  VGA_B
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

   // Row stride is built from two shifts, so FB_WIDTH must be a sum of two powers of two.
   localparam int FB_SH_HI = $clog2(FB_WIDTH) - 1;
   localparam int FB_SH_LO = $clog2(FB_WIDTH - (1 << FB_SH_HI));

   logic        ph;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic        visible;
   logic        hs_active;
   logic        vs_active;
   logic [14:0] fb_x;
   logic [14:0] fb_y;

   always_comb begin
      visible   = (hcount < H_VIS) && (vcount < V_VIS);
      hs_active = (hcount >= HS_FIRST) && (hcount <= HS_LAST);
      vs_active = (vcount >= VS_FIRST) && (vcount <= VS_LAST);
      fb_x      = 15'(hcount >> SCALE_SHIFT);
      fb_y      = 15'(vcount >> SCALE_SHIFT);
      rd_addr   = visible ? (fb_y << FB_SH_HI) + (fb_y << FB_SH_LO) + fb_x : 15'd0;
   end

   // Pixel phase and scan position; the position only moves on the ph==1 edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         ph     <= 1'b0;
         hcount <= '0;
         vcount <= '0;
      end else begin
         ph <= ~ph;
         if (ph) begin
            if (hcount == H_LAST) begin
               hcount <= '0;
               vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
            end else begin
               hcount <= hcount + 10'd1;
            end
         end
      end
   end

   // rd_data here belongs to the position being left, its address having settled a clk earlier.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_start <= 1'b0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
      end else begin
         frame_start <= ph && (hcount == H_LAST) && (vcount == V_LAST);
         if (ph) begin
            VGA_HS      <= ~hs_active;
            VGA_VS      <= ~vs_active;
            VGA_BLANK_N <= visible;
            VGA_R       <= {10{rd_data[2] & visible}};
            VGA_G       <= {10{rd_data[1] & visible}};
            VGA_B       <= {10{rd_data[0] & visible}};
         end
      end
   end

   assign VGA_CLK    = ph;
   assign VGA_SYNC_N = 1'b1;

endmodule
